rle_encoder_p: RTL and testbench

//  Parametrised run-length encoder between capture front-end and sample memory/FIFO.

---
 rtl/rle_encoder_p_if.sv | 22 ++
 rtl/rle_encoder_p.sv | 125 ++++++++++++
 tb/tb_rle_encoder_p.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rle_encoder_p_if.sv
// Sample input and encoded-word output handshakes of the run-length encoder.
// master = capture side / downstream consumer, slave = encoder.
interface rle_encoder_p_if #(
    parameter int DW = 16
);
    logic [DW-2:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/rle_encoder_p.sv
// Run-length encoder: emits {0,sample} for the first sample of a run and {1,count} for repeats,
// through a small first-word-fall-through buffer that absorbs downstream backpressure.
module rle_encoder_p #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic            core_clk,
    input  logic            core_rst_n,
    input  logic            rle_en_i,
    input  logic            flush_i,
    output logic            busy_o,
    rle_encoder_p_if.slave  bus
);
    localparam int SW = DW - 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [SW-1:0] MAX_RUN  = {SW{1'b1}};
    localparam logic [SW-1:0] RUN_LAST = MAX_RUN - 1'b1;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_W    = (AW+1)'(1);
    localparam logic [AW:0]   TWO_W    = (AW+1)'(2);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] prev_q, prev_d;
    logic          have_prev_q, have_prev_d;
    logic          flush_pend_q, flush_pend_d;

    logic [AW:0]   free;
    logic [AW:0]   npush;
    logic [DW-1:0] word0, word1;
    logic [AW-1:0] wr_idx0, wr_idx1;
    logic          accept, pop, flush_go;

    assign free          = DEPTH_W - occ_q;
    assign bus.in_ready  = (free >= TWO_W) & ~flush_pend_q;
    assign bus.out_valid = (occ_q != '0);
    assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign flush_go      = flush_pend_q & (free != '0);
    assign busy_o        = (cnt_q != '0) | flush_pend_q | (occ_q != '0);
    assign wr_idx0       = wr_ptr_q[AW-1:0];
    assign wr_idx1       = wr_ptr_q[AW-1:0] + 1'b1;

    // A flush can never coincide with an accepted sample because in_ready is held low while it waits.
    always_comb begin
        word0        = '0;
        word1        = '0;
        npush        = '0;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        have_prev_d  = have_prev_q;
        flush_pend_d = flush_i | (flush_pend_q & ~flush_go);
        if (accept) begin
            if (rle_en_i && have_prev_q && (bus.in_data == prev_q)) begin
                if (cnt_q == RUN_LAST) begin
                    word0 = {1'b1, MAX_RUN};
                    npush = ONE_W;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q != '0) begin
                    word0 = {1'b1, cnt_q};
                    word1 = {1'b0, bus.in_data};
                    npush = TWO_W;
                end else begin
                    word0 = {1'b0, bus.in_data};
                    npush = ONE_W;
                end
                cnt_d       = '0;
                prev_d      = bus.in_data;
                have_prev_d = rle_en_i;
            end
        end else if (flush_go) begin
            if (cnt_q != '0) begin
                word0 = {1'b1, cnt_q};
                npush = ONE_W;
            end
            cnt_d       = '0;
            have_prev_d = 1'b0;
        end
        wr_ptr_d = wr_ptr_q + npush;
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        occ_d    = occ_q + npush - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            if (npush != '0) begin
                mem_q[wr_idx0] <= word0;
            end
            if (npush == TWO_W) begin
                mem_q[wr_idx1] <= word1;
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            have_prev_q  <= have_prev_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // The in_ready/flush thresholds are what keep the buffer from overflowing.
    a_no_overflow: assert property (@(posedge core_clk) disable iff (!core_rst_n)
        (int'(occ_q) + int'(npush) - int'(pop)) <= DEPTH);

endmodule

// File: tb/tb_rle_encoder_p.sv
// Scoreboarded bench for rle_encoder_p: a DW=16 instance for directed and random traffic
// and a DW=4 instance for run saturation and flush.
module tb_rle_encoder_p;
    logic clk;
    logic rstN;
    logic rleEnA, flushA, busyA;
    logic rleEnB, flushB, busyB;
    logic directReadyA, directReadyB, randReady, rndReady;
    logic decodeMode;
    logic [14:0] lastS;

    int total;
    int bad;

    logic [15:0] expA[$];
    logic [3:0]  expB[$];
    logic [14:0] sampQ[$];

    rle_encoder_p_if #(.DW(16)) busA ();
    rle_encoder_p_if #(.DW(4))  busB ();

    rle_encoder_p #(.DW(16), .DEPTH(4)) dutA (
        .core_clk   (clk),
        .core_rst_n (rstN),
        .rle_en_i   (rleEnA),
        .flush_i    (flushA),
        .busy_o     (busyA),
        .bus        (busA)
    );

    rle_encoder_p #(.DW(4), .DEPTH(4)) dutB (
        .core_clk   (clk),
        .core_rst_n (rstN),
        .rle_en_i   (rleEnB),
        .flush_i    (flushB),
        .busy_o     (busyB),
        .bus        (busB)
    );

    assign busA.out_ready = randReady ? rndReady : directReadyA;
    assign busB.out_ready = directReadyB;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rndReady <= ($urandom_range(0, 3) != 0);

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Word monitor: exact-word compare in directed mode, run-length decode in random mode.
    always @(negedge clk) begin
        if (busA.out_valid && busA.out_ready) begin
            if (decodeMode) begin
                if (!busA.out_data[15]) begin
                    if (sampQ.size() == 0) begin
                        checkOutput("A dec extra sample", 0, 1);
                    end else begin
                        checkOutput("A dec sample", 32'(busA.out_data[14:0]), 32'(sampQ.pop_front()));
                    end
                    lastS = busA.out_data[14:0];
                end else begin
                    checkOutput("A dec count nonzero", 32'(busA.out_data[14:0] != 0), 1);
                    for (int i = 0; i < int'(busA.out_data[14:0]); i++) begin
                        if (sampQ.size() == 0) begin
                            checkOutput("A dec extra repeat", 0, 1);
                            break;
                        end
                        checkOutput("A dec repeat", 32'(lastS), 32'(sampQ.pop_front()));
                    end
                end
            end else if (expA.size() == 0) begin
                checkOutput("A extra word", 32'(expA.size()), 1);
            end else begin
                checkOutput("A word", 32'(busA.out_data), 32'(expA.pop_front()));
            end
        end
        if (busB.out_valid && busB.out_ready) begin
            if (expB.size() == 0) begin
                checkOutput("B extra word", 32'(expB.size()), 1);
            end else begin
                checkOutput("B word", 32'(busB.out_data), 32'(expB.pop_front()));
            end
        end
    end

    task automatic applyStimulus(input bit useB, input logic [14:0] s, input logic en);
        int guard;
        guard = 0;
        if (useB) begin
            rleEnB        = en;
            busB.in_data  = s[2:0];
            busB.in_valid = 1'b1;
        end else begin
            rleEnA        = en;
            busA.in_data  = s;
            busA.in_valid = 1'b1;
        end
        @(negedge clk);
        while (!(useB ? busB.in_ready : busA.in_ready) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            checkOutput("in_ready timeout", 0, 1);
        end else if (!useB && decodeMode) begin
            sampQ.push_back(s);
        end
        @(posedge clk);
        #1;
        busA.in_valid = 1'b0;
        busB.in_valid = 1'b0;
    endtask

    task automatic pulseFlush(input bit useB);
        if (useB) flushB = 1'b1;
        else flushA = 1'b1;
        @(posedge clk);
        #1;
        flushA = 1'b0;
        flushB = 1'b0;
    endtask

    task automatic waitDrain(input bit useB, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (n < budget &&
               (useB ? (expB.size() != 0 || busB.out_valid)
                     : (expA.size() != 0 || sampQ.size() != 0 || busA.out_valid))) begin
            @(negedge clk);
            n++;
        end
        if (useB) checkOutput("B drain left", 32'(expB.size()), 0);
        else checkOutput("A drain left", 32'(expA.size() + sampQ.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        rstN = 1'b0;
        rleEnA = 1'b1;
        rleEnB = 1'b1;
        flushA = 1'b0;
        flushB = 1'b0;
        directReadyA = 1'b1;
        directReadyB = 1'b1;
        randReady = 1'b0;
        decodeMode = 1'b0;
        lastS = '0;
        busA.in_data = '0;
        busA.in_valid = 1'b0;
        busB.in_data = '0;
        busB.in_valid = 1'b0;

        #2;
        checkOutput("rst A out_valid", 32'(busA.out_valid), 0);
        checkOutput("rst A out_data", 32'(busA.out_data), 0);
        checkOutput("rst A busy", 32'(busyA), 0);
        checkOutput("rst A in_ready", 32'(busA.in_ready), 1);
        checkOutput("rst B out_valid", 32'(busB.out_valid), 0);
        checkOutput("rst B out_data", 32'(busB.out_data), 0);
        checkOutput("rst B busy", 32'(busyB), 0);
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed run 0x1234 x5 then 0x0001");
        expA.push_back(16'h1234);
        expA.push_back(16'h8004);
        expA.push_back(16'h0001);
        repeat (5) applyStimulus(1'b0, 15'h1234, 1'b1);
        applyStimulus(1'b0, 15'h0001, 1'b1);
        waitDrain(1'b0, 50);

        $display("[TB] DW=4 saturation and flush");
        expB.push_back(4'h5);
        expB.push_back(4'hF);
        expB.push_back(4'hA);
        repeat (10) applyStimulus(1'b1, 15'h5, 1'b1);
        @(negedge clk);
        checkOutput("B busy with count", 32'(busyB), 1);
        @(posedge clk);
        #1;
        pulseFlush(1'b1);
        waitDrain(1'b1, 50);
        checkOutput("B busy after flush", 32'(busyB), 0);

        $display("[TB] bypass mode and bypass toggle with pending count");
        repeat (3) begin
            expA.push_back(16'h0007);
            applyStimulus(1'b0, 15'h0007, 1'b0);
        end
        expA.push_back(16'h0007);
        expA.push_back(16'h8003);
        expA.push_back(16'h0009);
        repeat (4) applyStimulus(1'b0, 15'h0007, 1'b1);
        applyStimulus(1'b0, 15'h0009, 1'b0);
        waitDrain(1'b0, 50);

        $display("[TB] backpressure");
        directReadyA = 1'b0;
        for (int i = 0; i < 6; i++) expA.push_back((i % 2 == 0) ? 16'h0001 : 16'h0002);
        applyStimulus(1'b0, 15'h0001, 1'b1);
        applyStimulus(1'b0, 15'h0002, 1'b1);
        applyStimulus(1'b0, 15'h0001, 1'b1);
        @(negedge clk);
        checkOutput("bp in_ready low", 32'(busA.in_ready), 0);
        checkOutput("bp out_valid", 32'(busA.out_valid), 1);
        checkOutput("bp head", 32'(busA.out_data), 32'h0001);
        @(posedge clk);
        #1;
        directReadyA = 1'b1;
        applyStimulus(1'b0, 15'h0002, 1'b1);
        applyStimulus(1'b0, 15'h0001, 1'b1);
        applyStimulus(1'b0, 15'h0002, 1'b1);
        waitDrain(1'b0, 50);

        $display("[TB] reset with buffered words");
        directReadyA = 1'b0;
        applyStimulus(1'b0, 15'h0011, 1'b1);
        applyStimulus(1'b0, 15'h0022, 1'b1);
        applyStimulus(1'b0, 15'h0033, 1'b1);
        @(negedge clk);
        checkOutput("pre-reset out_valid", 32'(busA.out_valid), 1);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("mid reset out_valid", 32'(busA.out_valid), 0);
        checkOutput("mid reset out_data", 32'(busA.out_data), 0);
        checkOutput("mid reset busy", 32'(busyA), 0);
        expA.delete();
        expB.delete();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        directReadyA = 1'b1;
        expA.push_back(16'h0033);
        applyStimulus(1'b0, 15'h0033, 1'b1);
        waitDrain(1'b0, 50);

        $display("[TB] random traffic against decoder");
        pulseFlush(1'b0);
        decodeMode = 1'b1;
        randReady = 1'b1;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, 15'($urandom_range(0, 3)), ($urandom_range(0, 9) != 0));
            if ($urandom_range(0, 19) == 0) pulseFlush(1'b0);
        end
        pulseFlush(1'b0);
        waitDrain(1'b0, 3000);
        checkOutput("A busy at end", 32'(busyA), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
